// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// iteration-counter sizing.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One spare bit so the counter can reach n without wrapping.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between a requester (master) and the divider (slave).
interface seq_divider_if #(parameter int N = 8);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_sub_stage.sv
// W-bit gate-level ripple subtractor: a + ~b + 1, built one full-adder cell per bit.
module div_sub_stage #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff
);

  logic [W-1:0] bx;
  logic [W-1:0] c;

  // Subtract mode: B inverted through XOR, carry-in tied high.
  assign bx   = b ^ {W{1'b1}};
  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign diff[i] = a[i] ^ bx[i] ^ c[i];
    if (i < W - 1) begin : g_cy
      assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, start/done handshake.
module seq_divider #(
  parameter int N = 8
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  import seq_divider_pkg::*;

  localparam int CW = cnt_w(N);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  dsr_q, dsr_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    r_shift;
  logic [N:0]    t_diff;

  // The partial remainder is kept n bits wide: after a restore its top bit is
  // always 0, so only the shifted (n+1)-bit trial value needs the extra bit.
  assign r_shift = {r_q, q_q[N-1]};

  div_sub_stage #(.W(N + 1)) u_sub (
    .a    (r_shift),
    .b    ({1'b0, dsr_q}),
    .diff (t_diff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dsr_d = bus.divisor;
          if (bus.divisor != '0) begin
            r_d     = '0;
            q_d     = bus.dividend;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Trial difference MSB clear means no borrow: keep it, quotient bit 1.
        if (!t_diff[N]) begin
          r_d = t_diff[N-1:0];
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          r_d = r_shift[N-1:0];
          q_d = {q_q[N-2:0], 1'b0};
        end
        if (cnt_q == CW'(N - 1)) begin
          quo_d   = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != ST_IDLE);
    bus.done = (state_q == ST_DONE);
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed + random bench for seq_divider (n=8) against a plain-arithmetic model.
module tb_seq_divider;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one division, wait for done, check latency, results and pulse width.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    int          cyc;
    bit          seen;
    logic [31:0] eq, er, edz;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    cyc  = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (b == 0) begin
      eq = 32'(2**N - 1); er = 32'(a); edz = 1;
    end else begin
      eq = 32'(a) / 32'(b); er = 32'(a) % 32'(b); edz = 0;
    end
    chk({tag, "_latency"}, seen ? 32'(cyc) : 32'hFFFF, (b == 0) ? 32'd1 : 32'(N + 1));
    chk({tag, "_quot"}, 32'(bus.quotient), eq);
    chk({tag, "_rem"}, 32'(bus.remainder), er);
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), edz);
    if (b != 0) begin
      chk({tag, "_identity"}, 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
      chk({tag, "_rem_lt_dsr"}, 32'(bus.remainder < b), 32'd1);
    end
    @(posedge clk); #1;
    chk({tag, "_done_width"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hold_quot"}, 32'(bus.quotient), eq);
  endtask

  initial begin
    int          ndone;
    int          first_at, second_at;
    logic [N-1:0] ra, rb;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1;
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_quot", 32'(bus.quotient), 0);
    chk("reset_rem", 32'(bus.remainder), 0);
    chk("reset_dbz", 32'(bus.div_by_zero), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'd137, 8'd3, "d137_3");
    do_op(8'd255, 8'd255, "d255_255");
    do_op(8'd4, 8'd10, "d4_10");
    do_op(8'd200, 8'd0, "d200_0");
    do_op(8'd255, 8'd1, "d255_1");

    // A start pulse while busy must be dropped, not queued.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd170; bus.divisor = 8'd170;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0; first_at = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 3) begin
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd2;
      end
      if (i == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (first_at == 0) first_at = i;
      end
      @(posedge clk); #1;
    end
    chk("busy_ignore_pulses", 32'(ndone), 1);
    chk("busy_ignore_latency", 32'(first_at), 32'(N + 1));
    chk("busy_ignore_quot", 32'(bus.quotient), 1);
    chk("busy_ignore_rem", 32'(bus.remainder), 0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_quot", 32'(bus.quotient), 0);
    chk("midrst_rem", 32'(bus.remainder), 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'd100, 8'd7, "after_rst_100_7");

    // Start held high through DONE relaunches at the minimum issue interval.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
    @(posedge clk); #1;
    ndone = 0; first_at = 0; second_at = 0;
    for (int i = 1; i <= 2 * N + 3; i++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (first_at == 0) first_at = i;
        else if (second_at == 0) second_at = i;
      end
      if (i < 2 * N + 3) begin
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", 32'(ndone), 2);
    chk("b2b_first", 32'(first_at), 32'(N + 1));
    chk("b2b_interval", 32'(second_at - first_at), 32'(N + 2));
    chk("b2b_quot", 32'(bus.quotient), 10);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_idle", 32'(bus.busy), 0);

    for (int k = 0; k < 500; k++) begin
      ra = N'($urandom_range(0, 2**N - 1));
      rb = N'($urandom_range(1, 2**N - 1));
      do_op(ra, rb, $sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
